// File: rtl/cg_mem_master.sv
// cg_mem_master: single-outstanding core-to-memory request sequencer with read watchdog.
// Define CG_MEM_MASTER_STATS_EN to add read/write/timeout event counters.
module cg_mem_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wen,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata
`ifdef CG_MEM_MASTER_STATS_EN
    ,
    output logic [31:0]           stat_rd_cnt,
    output logic [31:0]           stat_wr_cnt,
    output logic [31:0]           stat_to_cnt
`endif
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] RD_ADDR = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;
    localparam int         WDW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  err_q, err_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic                  rdy_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                addr_d  = req_addr;
                wdat_d  = req_wdata;
                state_d = req_we ? WR : RD_ADDR;
            end
            WR: state_d = wready ? IDLE : WR;
            RD_ADDR: if (arready) begin
                state_d = RD_WAIT;
                wd_d    = '0;
            end
            RD_WAIT: if (rvalid) begin
                rdat_d  = rdata;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (wd_q == WD_LAST) begin
                rdat_d  = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                wd_d = wd_q + 1'b1;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // rdy_q keeps req_ready low while reset is held; it rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            rdy_q   <= 1'b1;
        end
    end

    assign req_ready  = rdy_q && (state_q == IDLE);
    assign wen        = (state_q == WR);
    assign wvalid     = (state_q == WR);
    assign arvalid    = (state_q == RD_ADDR);
    assign rready     = (state_q == RD_ADDR) || (state_q == RD_WAIT);
    assign resp_valid = (state_q == RESP);
    assign waddr      = addr_q;
    assign araddr     = addr_q;
    assign wdata      = wdat_q;
    assign resp_rdata = rdat_q;
    assign resp_err   = err_q;

`ifdef CG_MEM_MASTER_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, to_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            if (state_q == RD_WAIT && rvalid) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (state_q == WR && wready) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (state_q == RD_WAIT && !rvalid && wd_q == WD_LAST) to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;
    assign stat_to_cnt = to_cnt_q;
`endif
endmodule

// File: tb/tb_cg_mem_master.sv
// tb_cg_mem_master: directed transactions against a phase-level model and a simple bench memory.
module tb_cg_mem_master;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, resp_ready, wready, arready, rvalid;
    logic [31:0] req_addr, req_wdata, rdata;
    logic        req_ready, resp_valid, resp_err, wen, wvalid, arvalid, rready;
    logic [31:0] resp_rdata, waddr, wdata, araddr;
`ifdef CG_MEM_MASTER_STATS_EN
    logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_to_cnt;
`endif

    cg_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .waddr(waddr), .wdata(wdata), .wen(wen), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rdata(rdata)
`ifdef CG_MEM_MASTER_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_to_cnt(stat_to_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef enum {P_IDLE, P_WR, P_RA, P_RW, P_RESP} ph_t;
    ph_t         ph = P_IDLE;
    logic        chk_en = 1'b0;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic        exp_err;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int          vectors = 0, miscompares = 0;
    int          cyc = 0, t_acc = 0, t_ar = 0, t_resp = 0;
    logic        rv_prev = 1'b0;
    logic [31:0] cap_rdata;
    logic        cap_err;
    int          n_rd = 0, n_wr = 0, n_to = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) if (wvalid && wen && wready) mem[waddr[7:0]] <= wdata;

    // Per-cycle compare: handshake outputs always, payloads only in the phase that presents them.
    always @(negedge clk) begin
        cyc++;
        if (req_valid && req_ready) t_acc = cyc;
        if (arvalid && arready) t_ar = cyc;
        if (resp_valid && !rv_prev) t_resp = cyc;
        rv_prev = resp_valid;
        if (resp_valid) begin
            cap_rdata = resp_rdata;
            cap_err   = resp_err;
        end
        if (chk_en) begin
            chk("req_ready", req_ready, ph == P_IDLE);
            chk("wen", wen, ph == P_WR);
            chk("wvalid", wvalid, ph == P_WR);
            chk("arvalid", arvalid, ph == P_RA);
            chk("rready", rready, ph == P_RA || ph == P_RW);
            chk("resp_valid", resp_valid, ph == P_RESP);
            if (ph == P_WR) begin
                chk("waddr", waddr, exp_addr);
                chk("wdata", wdata, exp_wdata);
            end
            if (ph == P_RA) chk("araddr", araddr, exp_addr);
            if (ph == P_RESP) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", resp_err, exp_err);
            end
        end
    end

    task automatic step(input ph_t p);
        @(posedge clk);
        #1;
        ph = p;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int stall);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        exp_addr = a; exp_wdata = d;
        step(P_WR);
        req_valid = 1'b0;
        repeat (stall) step(P_WR);
        wready = 1'b1;
        step(P_IDLE);
        wready = 1'b0;
        ref_mem[a[7:0]] = d;
        n_wr++;
    endtask

    // r_lat: RD_WAIT cycle (1-based) in which rvalid arrives; 0 means never.
    task automatic rd(input logic [31:0] a, input int ar_stall, input int r_lat, input int resp_stall);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom;
        exp_addr = a;
        step(P_RA);
        req_valid = 1'b0;
        for (int i = 0; i < ar_stall; i++) begin
            rvalid = i[0];
            rdata  = 32'hBAD0_0000 | i;
            step(P_RA);
        end
        rvalid = 1'b0;
        arready = 1'b1;
        step(P_RW);
        arready = 1'b0;
        if (r_lat == 0) begin
            repeat (TO - 1) step(P_RW);
            exp_rdata = '0; exp_err = 1'b1;
            step(P_RESP);
            n_to++;
        end else begin
            repeat (r_lat - 1) step(P_RW);
            rvalid = 1'b1; rdata = mem[araddr[7:0]];
            exp_rdata = ref_mem[a[7:0]]; exp_err = 1'b0;
            step(P_RESP);
            rvalid = 1'b0;
            n_rd++;
        end
        repeat (resp_stall) step(P_RESP);
        resp_ready = 1'b1;
        step(P_IDLE);
        resp_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_wen"}, wen, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
        #12;
        chk_zero("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(P_IDLE);
        chk_en = 1'b1;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        repeat (2) step(P_IDLE);
        rvalid = 1'b0;

        wr(32'h10, 32'hDEADBEEF, 0);
        rd(32'h10, 0, 1, 0);
        chk("lit_rd_data", cap_rdata, 32'hDEADBEEF);
        chk("lit_rd_err", cap_err, 0);
        chk("lit_rd_latency", t_resp - t_acc, 3);

        wr(32'h20, 32'h1234_5678, 3);
        rd(32'h20, 5, 2, 0);
        chk("lit_bp_data", cap_rdata, 32'h1234_5678);

        rd(32'h10, 0, 1, 4);
        chk("lit_stall_data", cap_rdata, 32'hDEADBEEF);

        rd(32'h30, 0, 0, 0);
        chk("lit_to_err", cap_err, 1);
        chk("lit_to_data", cap_rdata, 0);
        chk("lit_to_latency", t_resp - t_ar - 1, 16);

        rd(32'h20, 0, TO, 0);
        chk("lit_tie_err", cap_err, 0);
        chk("lit_tie_data", cap_rdata, 32'h1234_5678);

        wr(32'h30, 32'hA5A5_5A5A, 0);
        rd(32'h30, 1, 3, 0);
        chk("lit_after_to_data", cap_rdata, 32'hA5A5_5A5A);

        // Abandon a read mid-RD_WAIT with an asynchronous reset pulse.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; exp_addr = 32'h10;
        step(P_RA);
        req_valid = 1'b0; arready = 1'b1;
        step(P_RW);
        arready = 1'b0;
        repeat (2) step(P_RW);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0; rvalid = 1'b1; rdata = 32'h7777_7777;
        #1;
        chk_zero("async");
        n_rd = 0; n_wr = 0; n_to = 0;
        @(posedge clk); #1;
        rvalid = 1'b0; rst_n = 1'b1;
        step(P_IDLE);
        chk_en = 1'b1;
        repeat (3) step(P_IDLE);

`ifdef CG_MEM_MASTER_STATS_EN
        wr(32'h40, 32'h1, 0);
        wr(32'h41, 32'h2, 2);
        wr(32'h42, 32'h3, 0);
        rd(32'h40, 0, 1, 0);
        rd(32'h41, 0, 0, 0);
        rd(32'h42, 2, 4, 1);
        chk("stat_wr_cnt", stat_wr_cnt, n_wr);
        chk("stat_rd_cnt", stat_rd_cnt, n_rd);
        chk("stat_to_cnt", stat_to_cnt, n_to);
        chk("lit_stat_wr", stat_wr_cnt, 3);
        chk("lit_stat_rd", stat_rd_cnt, 2);
        chk("lit_stat_to", stat_to_cnt, 1);
`else
        rd(32'h10, 0, 1, 0);
        chk("lit_post_rst_data", cap_rdata, 32'hDEADBEEF);
`endif
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
